// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences one 8-bit MAC dot product from a weight/activation memory
// Ports:
//   i_clk, i_reset             clock, synchronous active-low reset
//   i_start, i_abort           run request (IDLE only), cancel current run
//   i_num_inputs               pair count, clamped to N_MAX
//   o_busy, o_done, o_result   status, one-cycle done pulse, held sum
//   o_mem_addr                 memory read address (1-cycle read latency)
//   i_mem_weight, i_mem_in     memory read data
//   o_mac_weight, o_mac_in     MAC operands (0 when no valid pair)
//   o_mac_forget               drop old accumulator on pair 0
//   o_mac_oe, o_mac_reset      MAC output enable, active-high MAC reset
//   i_mac_out                  MAC accumulator (high-Z unless o_mac_oe)
module mac_sequencer #(
  parameter int N_MAX  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W:0]   i_num_inputs,
  output logic              o_busy,
  output logic              o_done,
  output logic [7:0]        o_result,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_weight,
  input  logic [7:0]        i_mem_in,
  output logic [7:0]        o_mac_weight,
  output logic [7:0]        o_mac_in,
  output logic              o_mac_forget,
  output logic              o_mac_oe,
  output logic              o_mac_reset,
  input  logic [7:0]        i_mac_out
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [ADDR_W:0] C_NMAX = N_MAX[ADDR_W:0];
  localparam logic [ADDR_W:0] C_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  logic [2:0]      r_state;
  logic [ADDR_W:0] r_n;
  logic [ADDR_W:0] r_cnt;
  logic            r_valid;
  logic            r_first;
  logic            r_forget;
  logic            r_abort;
  logic [7:0]      r_result;
  logic [ADDR_W:0] w_n;
  logic            w_abort;
  logic            w_last;
  assign w_n     = (i_num_inputs > C_NMAX) ? C_NMAX : i_num_inputs;
  assign w_abort = i_abort && (r_state != S_IDLE);
  assign w_last  = r_cnt == r_n - C_ONE;
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_first  <= 1'b0;
      r_forget <= 1'b0;
      r_abort  <= 1'b0;
      r_result <= '0;
    end else begin
      r_abort  <= w_abort;
      // memory data trails the address by one cycle; forget trails pair 0 by one more
      r_valid  <= (r_state == S_FETCH) && !i_abort;
      r_first  <= (r_state == S_FETCH) && (r_cnt == '0) && !i_abort;
      r_forget <= r_first && !i_abort;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (i_start) begin
            r_n     <= w_n;
            r_cnt   <= '0;
            r_state <= (w_n == '0) ? S_DONE : S_FETCH;
            if (w_n == '0) r_result <= '0;
          end
          S_FETCH: begin
            r_cnt   <= w_last ? '0 : r_cnt + C_ONE;
            r_state <= w_last ? S_DRAIN : S_FETCH;
          end
          S_DRAIN: begin
            r_cnt   <= (r_cnt == C_ONE) ? '0 : r_cnt + C_ONE;
            r_state <= (r_cnt == C_ONE) ? S_READ : S_DRAIN;
          end
          S_READ: begin
            r_result <= i_mac_out;
            r_state  <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
  assign o_busy       = r_state != S_IDLE;
  assign o_done       = r_state == S_DONE;
  assign o_result     = r_result;
  assign o_mem_addr   = (r_state == S_FETCH) ? r_cnt[ADDR_W-1:0] : '0;
  assign o_mac_weight = r_valid ? i_mem_weight : '0;
  assign o_mac_in     = r_valid ? i_mem_in : '0;
  assign o_mac_forget = r_forget;
  assign o_mac_oe     = r_state == S_READ;
  assign o_mac_reset  = !i_reset || r_abort;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed scoreboard bench for mac_sequencer with memory and MAC models
module tb_mac_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] num = '0;
  logic       busy, done, forget, oe, mac_rst;
  logic [7:0] result, mem_w, mem_x, mac_w, mac_x;
  logic [3:0] addr;
  wire  [7:0] mac_out;
  logic [7:0] mw [16];
  logic [7:0] mx [16];
  logic [7:0] rw, rx, acc;
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  mac_sequencer #(.N_MAX(16), .ADDR_W(4)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort),
    .i_num_inputs(num), .o_busy(busy), .o_done(done), .o_result(result),
    .o_mem_addr(addr), .i_mem_weight(mem_w), .i_mem_in(mem_x),
    .o_mac_weight(mac_w), .o_mac_in(mac_x), .o_mac_forget(forget),
    .o_mac_oe(oe), .o_mac_reset(mac_rst), .i_mac_out(mac_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    mem_w <= mw[addr];
    mem_x <= mx[addr];
  end
  always @(posedge clk) begin
    if (mac_rst) begin
      rw  <= '0;
      rx  <= '0;
      acc <= '0;
    end else begin
      rw  <= mac_w;
      rx  <= mac_x;
      acc <= (forget ? 8'd0 : acc) + 8'(rw * rx);
    end
  end
  assign mac_out = oe ? acc : 8'bz;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [7:0] dot(input int n);
    logic [7:0] s = '0;
    for (int i = 0; i < n; i++) s = s + 8'(mw[i] * mx[i]);
    return s;
  endfunction
  task automatic go(input int n);
    num = 5'(n);
    start = 1'b1;
    exp_q.push_back(dot(n > 16 ? 16 : n));
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input int n);
    int neff = n > 16 ? 16 : n;
    int exp_cyc = neff == 0 ? 1 : neff + 4;
    int done_cyc = -1;
    int fcnt = 0, fcyc = -1, ocnt = 0, bcnt = 0, aerr = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) tick();
      if (busy) bcnt++;
      if (forget) begin fcnt++; fcyc = k; end
      if (oe) ocnt++;
      if (k <= neff && addr !== 4'(k - 1)) aerr++;
      if (done) begin done_cyc = k; break; end
    end
    chk("done_cycle", done_cyc, exp_cyc);
    chk("queue_size", exp_q.size(), 1);
    if (exp_q.size() > 0) chk("result", result, exp_q.pop_front());
    chk("forget_count", fcnt, neff > 0 ? 1 : 0);
    if (neff > 0) chk("forget_cycle", fcyc, 3);
    chk("oe_count", ocnt, neff > 0 ? 1 : 0);
    chk("busy_cycles", bcnt, exp_cyc);
    chk("addr_errors", aerr, 0);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_addr", addr, 0);
    chk("rst_oe", oe, 0);
    chk("rst_forget", forget, 0);
    chk("rst_mac_w", mac_w, 0);
    chk("rst_mac_reset", mac_rst, 1);
    rst_n = 1'b1;
    #1;
    chk("run_mac_reset", mac_rst, 0);
    mw[0] = 2; mw[1] = 3; mw[2] = 4; mx[0] = 5; mx[1] = 6; mx[2] = 7;
    go(3);
    wait_done(3);
    mw[0] = 16; mw[1] = 16; mx[0] = 16; mx[1] = 1;
    go(2);
    wait_done(2);
    mw[0] = 10; mx[0] = 10;
    go(1);
    wait_done(1);
    mw[0] = 1; mx[0] = 1;
    go(1);
    wait_done(1);
    for (int i = 0; i < 4; i++) begin mw[i] = 8'(i + 9); mx[i] = 8'(i + 3); end
    go(4);
    void'(exp_q.pop_back());
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_mac_reset", mac_rst, 1);
    tick();
    chk("abort_mac_reset_end", mac_rst, 0);
    for (int k = 0; k < 8; k++) begin
      chk("abort_no_done", done, 0);
      tick();
    end
    chk("abort_result_kept", result, 1);
    mw[0] = 3; mw[1] = 4; mx[0] = 5; mx[1] = 6;
    go(2);
    wait_done(2);
    mw[0] = 5; mx[0] = 5;
    num = 5'd1;
    start = 1'b1;
    repeat (3) exp_q.push_back(dot(1));
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("held_done", done, (k == 5 || k == 11 || k == 17) ? 1 : 0);
      if (done && exp_q.size() > 0) chk("held_result", result, exp_q.pop_front());
    end
    start = 1'b0;
    tick();
    chk("held_idle", busy, 0);
    chk("held_queue", exp_q.size(), 0);
    for (int i = 0; i < 16; i++) begin mw[i] = 8'(i + 1); mx[i] = 3; end
    go(20);
    wait_done(20);
    go(0);
    wait_done(0);
    mw[0] = 3; mx[0] = 3;
    go(1);
    wait_done(1);
    mw[0] = 3; mw[1] = 4; mx[0] = 5; mx[1] = 6;
    go(2);
    void'(exp_q.pop_back());
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("drain_rst_mac_reset", mac_rst, 1);
    tick();
    chk("drain_rst_busy", busy, 0);
    chk("drain_rst_result", result, 0);
    rst_n = 1'b1;
    tick();
    mw[0] = 7; mx[0] = 9;
    go(1);
    wait_done(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
